instruction_queue: RTL and testbench



---
 rtl/instruction_queue.sv | 92 +++++++++
 tb/tb_instruction_queue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - fetch-to-decode instruction/pc FIFO
// Optional same-cycle empty bypass: define INSTRQ_BYPASS_EN.
module instruction_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_instruction,
   input  logic [DATA_W-1:0]          in_pc,
   output logic                       in_ready,
   input  logic                       flush,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_instruction,
   output logic [DATA_W-1:0]          out_pc,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [DATA_W-1:0] mem_pc    [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;

   logic full;
   logic empty;
   logic push;
   logic bypass;
   logic wr_en;
   logic rd_en;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign in_ready  = !full && !rst;
   assign push      = in_valid && in_ready;
   assign occupancy = count;

   // Head presentation; an empty queue drives zeros, or the incoming entry when bypass is built in.
   always_comb begin
      bypass          = 1'b0;
      out_valid       = !empty;
      out_instruction = '0;
      out_pc          = '0;
      if (!empty) begin
         out_instruction = mem_instr[rd_ptr];
         out_pc          = mem_pc[rd_ptr];
      end
`ifdef INSTRQ_BYPASS_EN
      else if (in_valid && !flush && !rst) begin
         bypass          = 1'b1;
         out_valid       = 1'b1;
         out_instruction = in_instruction;
         out_pc          = in_pc;
      end
`endif
   end

   // A bypassed entry consumed the same cycle never touches storage.
   assign wr_en = push && !(bypass && out_ready);
   assign rd_en = !empty && out_ready;

   // Storage writes; contents survive reset/flush since the pointers invalidate them.
   always_ff @(posedge clk) begin
      if (wr_en && !flush && !rst) begin
         mem_instr[wr_ptr] <= in_instruction;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   // Pointer and count update; reset and flush both empty the queue and drop same-cycle traffic.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard bench for instruction_queue
module tb_instruction_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       in_valid;
   logic [DATA_W-1:0]          in_instruction;
   logic [DATA_W-1:0]          in_pc;
   logic                       in_ready;
   logic                       flush;
   logic                       out_valid;
   logic [DATA_W-1:0]          out_instruction;
   logic [DATA_W-1:0]          out_pc;
   logic                       out_ready;
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   int    n_checks = 0;
   int    n_fail   = 0;
   string phase    = "init";
   logic [63:0] sb[$];

   instruction_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_instruction  (in_instruction),
      .in_pc           (in_pc),
      .in_ready        (in_ready),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_ready       (out_ready),
      .occupancy       (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, compare against the model, then advance the model past the edge.
   task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic fl, input logic ordy);
      logic [63:0] head;
      logic        byp;
      logic        exp_ir;
      logic        exp_ov;
      @(negedge clk);
      rst            = r;
      in_valid       = iv;
      in_instruction = ins;
      in_pc          = pc;
      flush          = fl;
      out_ready      = ordy;
      #1;
      exp_ir = !r && (sb.size() != DEPTH);
      byp    = 1'b0;
`ifdef INSTRQ_BYPASS_EN
      byp    = (sb.size() == 0) && iv && !fl && !r;
`endif
      exp_ov = (sb.size() != 0) || byp;
      head   = byp ? {ins, pc} : ((sb.size() != 0) ? sb[0] : 64'd0);
      check("in_ready",  64'(in_ready),  64'(exp_ir));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("occupancy", 64'(occupancy), 64'(sb.size()));
      check("head",      {out_instruction, out_pc}, head);
      if (r || fl) begin
         sb.delete();
      end else begin
         if (exp_ov && ordy && !byp) void'(sb.pop_front());
         if (iv && exp_ir && !(byp && ordy)) sb.push_back({ins, pc});
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ordy);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);

      phase = "reset";
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      check("rst_occ",  64'(occupancy), 64'd0);
      check("rst_ir",   64'(in_ready),  64'd1);
      check("rst_ov",   64'(out_valid), 64'd0);
      check("rst_pc",   64'(out_pc),    64'd0);

      phase = "fill";
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hA0 + i, 32'(4 * i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hA4, 32'd16, 1'b0, 1'b0);
      idle(1'b0);
      check("full_occ", 64'(occupancy), 64'd4);
      check("full_ir",  64'(in_ready),  64'd0);
      check("full_pc",  64'(out_pc),    64'd0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      idle(1'b0);
      check("drain_ov", 64'(out_valid), 64'd0);

      phase = "stream";
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 32'hC0 + i, 32'(4 * i), 1'b0, 1'b1);
         if (i == 5) begin
`ifdef INSTRQ_BYPASS_EN
            check("stream_occ", 64'(occupancy), 64'd0);
`else
            check("stream_occ", 64'(occupancy), 64'd1);
`endif
         end
      end
      idle(1'b1);
      idle(1'b0);

      phase = "flush";
      step(1'b0, 1'b1, 32'hD0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hD1, 32'd4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hD2, 32'd8, 1'b1, 1'b0);
      idle(1'b0);
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_ov",  64'(out_valid), 64'd0);
      check("flush_ir",  64'(in_ready),  64'd1);
      step(1'b0, 1'b1, 32'hB0, 32'd0, 1'b0, 1'b0);
      idle(1'b0);
      check("target_ov",  64'(out_valid),       64'd1);
      check("target_ins", 64'(out_instruction), 64'hB0);
      idle(1'b1);

      phase = "wrap";
      step(1'b0, 1'b1, 32'hE0, 32'd0, 1'b0, 1'b0);
      for (int i = 1; i < 6; i++) step(1'b0, 1'b1, 32'hE0 + i, 32'(4 * i), 1'b0, 1'b1);
      idle(1'b0);
      check("wrap_pc",  64'(out_pc),    64'd20);
      check("wrap_occ", 64'(occupancy), 64'd1);
      idle(1'b1);

      phase = "midreset";
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hF0 + i, 32'(64 + 4 * i), 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'hF3, 32'd76, 1'b1, 1'b0);
      idle(1'b0);
      check("mr_occ", 64'(occupancy), 64'd0);
      check("mr_ov",  64'(out_valid), 64'd0);
      check("mr_ir",  64'(in_ready),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
